// File: rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv
// rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv - shared constants for the RAM-backed valid/ready FIFO controller
// Purpose: default RAM geometry and the width helper for the optional occupancy output.
// Ports: none.
// Config macro: NV_RAM_FIFO_CTRL_COUNT_EN (wr_count width comes from cnt_width()).
package nv_ram_rwsp_fifo_ctrl_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 129;
  localparam int DEPTH  = 2 ** AW_DEF;

  // Occupancy reaches 2**AW + 1 (slots plus the output register), so at least
  // 4 bits are needed for the default 8-deep macro.
  function automatic int cnt_width(input int aw);
    return ((aw + 1) > 4) ? (aw + 1) : 4;
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl_if.sv
// rtl/nv_ram_rwsp_fifo_ctrl_if.sv - push/pop and RAM-port bundle for the FIFO controller
// Purpose: groups the push side, pop side and RAM macro ports of nv_ram_rwsp_fifo_ctrl.
// Ports (signals):
//   wr_pvld/wr_prdy/wr_pd         push handshake and payload
//   rd_pvld/rd_prdy/rd_pd         pop handshake and payload
//   ram_wa/ram_we/ram_di          RAM write port
//   ram_ra/ram_re/ram_ore         RAM read address, address-register enable, output-register enable
//   ram_dout                      RAM output register
//   wr_count                      occupancy, only with NV_RAM_FIFO_CTRL_COUNT_EN
// Modports: slave = controller, master = surrounding logic (producer, consumer, RAM).
interface nv_ram_rwsp_fifo_ctrl_if
  import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
  logic [cnt_width(AW)-1:0] wr_count;
`endif

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
    , output wr_count
`endif
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
    , input wr_count
`endif
  );

endinterface

// File: rtl/nv_ram_fifo_rd_pipe.sv
// rtl/nv_ram_fifo_rd_pipe.sv - two-stage read pipeline tracker for the RAM macro
// Purpose: tracks whether the macro's address register (stage 1) and output
//   register (stage 2) hold live entries and generates re/ore from that.
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_ram_avail       at least one written entry has not been addressed yet
//   i_rd_prdy         downstream ready
//   o_ram_re          load the macro's address register this cycle
//   o_ram_ore         load the macro's output register this cycle
//   o_rd_pvld         output register holds live data
module nv_ram_fifo_rd_pipe
  import nv_ram_rwsp_fifo_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_ram_avail,
  input  logic i_rd_prdy,
  output logic o_ram_re,
  output logic o_ram_ore,
  output logic o_rd_pvld
);

  logic r_s1_vld;
  logic r_s2_vld;
  logic w_ore;
  logic w_re;

  // Stage 2 can accept new data when empty or when its current word leaves
  // on this edge; stage 1 likewise refills on the edge it hands off, which is
  // what sustains one transfer per cycle.
  assign w_ore = r_s1_vld & (~r_s2_vld | i_rd_prdy);
  assign w_re  = i_ram_avail & (~r_s1_vld | w_ore);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_re | (r_s1_vld & ~w_ore);
      r_s2_vld <= w_ore | (r_s2_vld & ~i_rd_prdy);
    end
  end

  assign o_ram_re  = w_re;
  assign o_ram_ore = w_ore;
  assign o_rd_pvld = r_s2_vld;

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// rtl/nv_ram_rwsp_fifo_ctrl.sv - valid/ready FIFO controller around a 2**AW-entry two-port RAM macro
// Purpose: drives the RAM write port and the re/ore read pipeline so the
//   macro behaves as a FIFO of 2**AW + 1 entries (slots plus output register).
// Ports:
//   nvdla_core_clk    clock
//   nvdla_core_rstn   asynchronous active-low reset
//   bus (slave)       push/pop handshakes, RAM ports, optional wr_count
// Config macro: NV_RAM_FIFO_CTRL_COUNT_EN adds the registered wr_count output.
module nv_ram_rwsp_fifo_ctrl
  import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)
(
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nv_ram_rwsp_fifo_ctrl_if.slave bus
);

  localparam int         NSLOT     = 1 << AW;
  localparam logic [AW:0] SLOT_FULL = (AW + 1)'(NSLOT);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_slot_cnt;  // slots holding data not yet moved to the output register
  logic [AW:0]   r_ram_cnt;   // written entries not yet addressed

  logic w_wr_prdy;
  logic w_ram_we;
  logic w_ram_re;
  logic w_ram_ore;
  logic w_rd_pvld;
  logic w_ram_avail;

  // Ready is low only while every slot is live; a slot released by ore
  // shows up as ready one cycle later.
  assign w_wr_prdy = (r_slot_cnt != SLOT_FULL);

  // Ready is held high through reset, so the write strobe is gated with
  // reset to keep the macro untouched while the controller is cleared.
  assign w_ram_we    = bus.wr_pvld & w_wr_prdy & nvdla_core_rstn;
  assign w_ram_avail = (r_ram_cnt != '0);

  nv_ram_fifo_rd_pipe u_rd_pipe (
    .i_clk       (nvdla_core_clk),
    .i_rstn      (nvdla_core_rstn),
    .i_ram_avail (w_ram_avail),
    .i_rd_prdy   (bus.rd_prdy),
    .o_ram_re    (w_ram_re),
    .o_ram_ore   (w_ram_ore),
    .o_rd_pvld   (w_rd_pvld)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_slot_cnt <= '0;
      r_ram_cnt  <= '0;
    end else begin
      if (w_ram_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_ram_re) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // The output register samples the old word on the ore edge, so the
      // slot counts as free from that edge on.
      case ({w_ram_we, w_ram_ore})
        2'b10:   r_slot_cnt <= r_slot_cnt + 1'b1;
        2'b01:   r_slot_cnt <= r_slot_cnt - 1'b1;
        default: r_slot_cnt <= r_slot_cnt;
      endcase
      case ({w_ram_we, w_ram_re})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
  localparam int CW = cnt_width(AW);

  logic [CW-1:0] r_wr_count;
  logic          w_pop;

  // Live entries = slots in use plus the output register; it moves only on
  // push or pop, since ore just shifts an entry between the two.
  assign w_pop = w_rd_pvld & bus.rd_prdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_count <= '0;
    end else begin
      case ({w_ram_we, w_pop})
        2'b10:   r_wr_count <= r_wr_count + 1'b1;
        2'b01:   r_wr_count <= r_wr_count - 1'b1;
        default: r_wr_count <= r_wr_count;
      endcase
    end
  end

  assign bus.wr_count = r_wr_count;
`endif

  assign bus.wr_prdy = w_wr_prdy;
  assign bus.rd_pvld = w_rd_pvld;
  assign bus.rd_pd   = bus.ram_dout;
  assign bus.ram_wa  = r_wr_ptr;
  assign bus.ram_we  = w_ram_we;
  assign bus.ram_di  = bus.wr_pd;
  assign bus.ram_ra  = r_rd_ptr;
  assign bus.ram_re  = w_ram_re;
  assign bus.ram_ore = w_ram_ore;

  a_slot_bound: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    r_slot_cnt <= SLOT_FULL);
  a_ram_le_slot: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    r_ram_cnt <= r_slot_cnt);

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// tb/tb_nv_ram_rwsp_fifo_ctrl.sv - self-checking bench for nv_ram_rwsp_fifo_ctrl
module tb_nv_ram_rwsp_fifo_ctrl;
  import nv_ram_rwsp_fifo_ctrl_pkg::*;

  localparam int AW = 3;
  localparam int DW = 129;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nv_ram_rwsp_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  nv_ram_rwsp_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  // RAM macro: registered read address, gated output register.
  logic [DW-1:0] ram_mem [8];
  logic [AW-1:0] ram_areg;
  logic [DW-1:0] ram_oreg;
  always @(posedge clk) begin
    if (bus.ram_we)  ram_mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re)  ram_areg <= bus.ram_ra;
    if (bus.ram_ore) ram_oreg <= ram_mem[ram_areg];
  end
  assign bus.ram_dout = ram_oreg;

  int n_chk = 0;
  int n_err = 0;

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] u;
    u = k;
    return {u[0], u * 32'h9e37_79b1, ~u, u ^ 32'h5a5a_a5a5, u};
  endfunction

  // Reference model: every accepted entry gets a serial number and passes
  // through four milestones (accepted, addressed, in output register, popped).
  // The address stage and the output register each hold one entry and may
  // refill on the same edge they hand off; slots are occupied from accept
  // until the entry reaches the output register.
  logic [DW-1:0] m_data [1024];

  initial begin : compare
    int n_acc, n_re, n_ore, n_pop;
    bit e_prdy, e_pvld, e_pop, e_ore, e_re, e_push, prev_stall;
    logic [DW-1:0] prev_pd;
    n_acc = 0; n_re = 0; n_ore = 0; n_pop = 0; prev_stall = 0; prev_pd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        n_acc = 0; n_re = 0; n_ore = 0; n_pop = 0; prev_stall = 0;
        chk1("r_wr_prdy", bus.wr_prdy, 1'b1);
        chk1("r_rd_pvld", bus.rd_pvld, 1'b0);
        chk1("r_ram_we", bus.ram_we, 1'b0);
        chk1("r_ram_re", bus.ram_re, 1'b0);
        chk1("r_ram_ore", bus.ram_ore, 1'b0);
        chki("r_ram_wa", int'(bus.ram_wa), 0);
        chki("r_ram_ra", int'(bus.ram_ra), 0);
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
        chki("r_wr_count", int'(bus.wr_count), 0);
`endif
      end else begin
        e_prdy = (n_acc - n_ore) != 8;
        e_pvld = n_ore > n_pop;
        e_pop  = e_pvld && bus.rd_prdy;
        e_ore  = (n_re > n_ore) && ((n_ore == n_pop) || e_pop);
        e_re   = (n_acc > n_re) && ((n_re == n_ore) || e_ore);
        e_push = bus.wr_pvld && e_prdy;
        chk1("m_wr_prdy", bus.wr_prdy, e_prdy);
        chk1("m_rd_pvld", bus.rd_pvld, e_pvld);
        chk1("m_ram_we", bus.ram_we, e_push);
        chk1("m_ram_re", bus.ram_re, e_re);
        chk1("m_ram_ore", bus.ram_ore, e_ore);
        chki("m_ram_wa", int'(bus.ram_wa), n_acc % 8);
        chki("m_ram_ra", int'(bus.ram_ra), n_re % 8);
        if (e_pvld) chkd("m_rd_pd", bus.rd_pd, m_data[n_pop % 1024]);
        if (e_push) chkd("m_ram_di", bus.ram_di, bus.wr_pd);
        if (prev_stall) chkd("stall_hold", bus.rd_pd, prev_pd);
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
        chki("m_wr_count", int'(bus.wr_count), n_acc - n_pop);
`endif
        prev_stall = bus.rd_pvld && !bus.rd_prdy;
        prev_pd    = bus.rd_pd;
        if (e_push) begin
          m_data[n_acc % 1024] = bus.wr_pd;
          n_acc++;
        end
        if (e_re)  n_re++;
        if (e_ore) n_ore++;
        if (e_pop) n_pop++;
      end
    end
  end

  logic [DW-1:0] pop_q [$];
  int            pop_cyc [$];

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn && bus.rd_pvld && bus.rd_prdy) begin
        pop_q.push_back(bus.rd_pd);
        pop_cyc.push_back(cyc);
      end
    end
  end

  logic          s_prdy, s_pvld;
  logic [DW-1:0] s_pd;
  int            s_cyc;

  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit rdy, output bit acc);
    bus.wr_pvld = pv;
    bus.wr_pd   = pd;
    bus.rd_prdy = rdy;
    @(negedge clk);
    s_prdy = bus.wr_prdy;
    s_pvld = bus.rd_pvld;
    s_pd   = bus.rd_pd;
    s_cyc  = cyc;
    acc    = pv && bus.wr_prdy && rstn;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base, input int n, input bit rdy, output int got);
    bit acc;
    got = 0;
    for (int t = 0; t < 4 * n + 20 && got < n; t++) begin
      step(1'b1, pat(base + got), rdy, acc);
      if (acc) got++;
    end
  endtask

  task automatic drain(input int want, input int rdy_pct, input int budget);
    bit acc;
    for (int t = 0; t < budget && pop_q.size() < want; t++)
      step(1'b0, '0, ($urandom_range(99) < rdy_pct), acc);
    bus.rd_prdy = 1'b0;
    chki("drain_count", pop_q.size(), want);
  endtask

  task automatic check_order(input string nm, input int base, input int n);
    for (int i = 0; i < n && i < pop_q.size(); i++) chkd(nm, pop_q[i], pat(base + i));
    pop_q.delete();
    pop_cyc.delete();
  endtask

  task automatic single_push(input logic [DW-1:0] d, input string tag);
    int re_off, ore_off, pv_off, pv_cnt;
    logic [DW-1:0] got;
    re_off = -1; ore_off = -1; pv_off = -1; pv_cnt = 0; got = '0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = d;
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    chk1({tag, "_accept"}, bus.wr_prdy, 1'b1);
    @(posedge clk);
    #1;
    bus.wr_pvld = 1'b0;
    for (int off = 1; off <= 6; off++) begin
      @(negedge clk);
      if (bus.ram_re && re_off < 0) re_off = off;
      if (bus.ram_ore && ore_off < 0) ore_off = off;
      if (bus.rd_pvld) begin
        if (pv_off < 0) pv_off = off;
        pv_cnt++;
        got = bus.rd_pd;
      end
      @(posedge clk);
      #1;
    end
    chki({tag, "_re_lat"}, re_off, 1);
    chki({tag, "_ore_lat"}, ore_off, 2);
    chki({tag, "_pvld_lat"}, pv_off, 3);
    chki({tag, "_pvld_cycles"}, pv_cnt, 1);
    chkd({tag, "_data"}, got, d);
    bus.rd_prdy = 1'b0;
    pop_q.delete();
    pop_cyc.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : drive
    bit acc;
    int got, first_acc, steps;
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = '0;
    bus.rd_prdy = 1'b0;
    rstn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst_wr_prdy", bus.wr_prdy, 1'b1);
    chk1("rst_rd_pvld", bus.rd_pvld, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // single push latency
    single_push(pat(1), "single");

    // nine entries fill slots plus output register; a tenth is refused
    fill(100, 9, 1'b0, got);
    chki("fill9_accepted", got, 9);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, pat(109), 1'b0, acc);
      chk1("full_no_accept", acc, 1'b0);
      chk1("full_wr_prdy", s_prdy, 1'b0);
      chk1("full_rd_pvld", s_pvld, 1'b1);
      chkd("full_head", s_pd, pat(100));
    end
    drain(9, 100, 40);
    check_order("fill9_order", 100, 9);

    // streaming, both sides always ready
    steps = 0;
    first_acc = -1;
    got = 0;
    for (int t = 0; t < 300 && got < 100; t++) begin
      step(1'b1, pat(200 + got), 1'b1, acc);
      steps++;
      if (acc) begin
        if (first_acc < 0) first_acc = s_cyc;
        got++;
      end
    end
    chki("stream_push_steps", steps, 100);
    drain(100, 100, 40);
    if (pop_cyc.size() == 100) begin
      chki("stream_fill_lat", pop_cyc[0] - first_acc, 3);
      chki("stream_no_bubble", pop_cyc[99] - pop_cyc[0], 99);
    end
    check_order("stream_order", 200, 100);

    // random push gaps and 50% consumer stalls
    got = 0;
    for (int t = 0; t < 1000 && got < 40; t++) begin
      step(($urandom_range(9) < 7), pat(400 + got), ($urandom_range(99) < 50), acc);
      if (acc) got++;
    end
    chki("rand_pushed", got, 40);
    drain(40, 50, 400);
    check_order("rand_order", 400, 40);

    // full FIFO with push and pop together
    fill(500, 9, 1'b0, got);
    chki("full2_accepted", got, 9);
    step(1'b1, pat(509), 1'b1, acc);
    chk1("fullpp_prdy_low", s_prdy, 1'b0);
    chk1("fullpp_no_accept", acc, 1'b0);
    chk1("fullpp_pvld", s_pvld, 1'b1);
    step(1'b1, pat(509), 1'b1, acc);
    chk1("fullpp_prdy_next", s_prdy, 1'b1);
    chk1("fullpp_accept", acc, 1'b1);
    got = 1;
    for (int t = 0; t < 40 && got < 6; t++) begin
      step(1'b1, pat(509 + got), 1'b1, acc);
      if (acc) got++;
    end
    chki("fullpp_pushed", got, 6);
    drain(15, 100, 60);
    check_order("fullpp_order", 500, 15);

    // reset with five entries held
    fill(600, 5, 1'b0, got);
    chki("prerst_accepted", got, 5);
    rstn = 1'b0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = pat(605);
    @(negedge clk);
    chk1("midrst_rd_pvld", bus.rd_pvld, 1'b0);
    chk1("midrst_wr_prdy", bus.wr_prdy, 1'b1);
    chk1("midrst_ram_we", bus.ram_we, 1'b0);
`ifdef NV_RAM_FIFO_CTRL_COUNT_EN
    chki("midrst_wr_count", int'(bus.wr_count), 0);
`endif
    @(posedge clk);
    #1;
    bus.wr_pvld = 1'b0;
    rstn = 1'b1;
    pop_q.delete();
    pop_cyc.delete();
    single_push(pat(700), "postrst");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
